// File: rtl/control_pipe_pkg.sv
// Shared decode constants, control bundle and sequencer state for the
// RV32I/M decode-to-execute control path.
package control_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam int ALUOP_MULDIV_BIT = 4;
  localparam int ALUOP_ALT_BIT    = 3;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_ZERO = 2'b01;
  localparam logic [1:0] SRCA_RS1  = 2'b11;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       pc_branch;
    logic       src_b_sel;
    logic       mem_to_reg;
    logic [1:0] src_a_sel;
    logic [4:0] alu_op;
    logic [2:0] imm_sel;
    logic [2:0] str_ctrl;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational D-stage decode of opcode/funct3/funct7 into the control bundle.
// An all-zero bundle is a bubble; illegal ops keep only valid/illegal/funct3.
module control_decode
  import control_pipe_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic       valid_d,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl_d
);

  logic known;
  logic is_md;
  logic illegal;

  always_comb begin
    known  = 1'b1;
    is_md  = (opcode == OP_ALUREG) && (funct7 == F7_MULDIV);
    ctrl_d = '0;
    ctrl_d.valid     = 1'b1;
    ctrl_d.src_a_sel = SRCA_RS1;
    ctrl_d.imm_sel   = IMM_NONE;
    ctrl_d.str_ctrl  = funct3;

    case (opcode)
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.src_b_sel  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.imm_sel    = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.src_b_sel = 1'b1;
        ctrl_d.imm_sel   = IMM_S;
      end
      OP_ALUREG: begin
        ctrl_d.reg_write                     = 1'b1;
        ctrl_d.alu_op[2:0]                   = funct3;
        ctrl_d.alu_op[ALUOP_ALT_BIT]         = funct7[5];
        ctrl_d.alu_op[ALUOP_MULDIV_BIT]      = is_md && (M_EXT != 0);
      end
      OP_ALUIMM: begin
        ctrl_d.reg_write             = 1'b1;
        ctrl_d.src_b_sel             = 1'b1;
        ctrl_d.imm_sel               = IMM_I;
        ctrl_d.alu_op[2:0]           = funct3;
        // Only the shift-right group uses funct7[5]; elsewhere those bits are immediate.
        ctrl_d.alu_op[ALUOP_ALT_BIT] = (funct3 == 3'b101) && funct7[5];
      end
      OP_BRANCH: begin
        ctrl_d.pc_branch   = 1'b1;
        ctrl_d.imm_sel     = IMM_B;
        ctrl_d.alu_op[2:0] = funct3;
      end
      OP_JAL: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.pc_branch = 1'b1;
        ctrl_d.src_a_sel = SRCA_PC;
        ctrl_d.imm_sel   = IMM_J;
      end
      OP_JALR: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.pc_branch = 1'b1;
        ctrl_d.src_a_sel = SRCA_PC;
        ctrl_d.imm_sel   = IMM_I;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_b_sel = 1'b1;
        ctrl_d.src_a_sel = SRCA_ZERO;
        ctrl_d.imm_sel   = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_b_sel = 1'b1;
        ctrl_d.src_a_sel = SRCA_PC;
        ctrl_d.imm_sel   = IMM_U;
      end
      default: known = 1'b0;
    endcase

    illegal = !known || (is_md && (M_EXT == 0));
    if (illegal) begin
      ctrl_d          = '0;
      ctrl_d.valid    = 1'b1;
      ctrl_d.imm_sel  = IMM_NONE;
      ctrl_d.str_ctrl = funct3;
      ctrl_d.illegal  = 1'b1;
    end

    if (!valid_d) begin
      ctrl_d = '0;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// ID/EX control register with flush/stall handling and a multi-cycle MUL/DIV
// sequencer that holds E and freezes the front end while an op is busy.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int M_EXT      = 1,
  parameter int MULDIV_LAT = 4,
  parameter int ALUOP_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_d,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               stall_e,
  input  logic               flush_e,
  output logic               valid_e,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               PCBranchE,
  output logic               SrcBSelE,
  output logic               MemtoRegE,
  output logic [1:0]         SrcASelE,
  output logic [ALUOP_W-1:0] ALUopE,
  output logic [2:0]         immSelE,
  output logic [2:0]         strCtrlE,
  output logic               illegal_e,
  output logic               muldiv_stall,
  output logic               muldiv_done
);

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 1);
  localparam bit         MULTI    = (MULDIV_LAT > 1);

  ctrl_t      dec;
  ctrl_t      e_d, e_q;
  seq_state_e state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic       done_d, done_q;

  control_decode #(
    .M_EXT(M_EXT)
  ) u_decode (
    .valid_d(valid_d),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .ctrl_d (dec)
  );

  // done_q marks the final E cycle: the one after the last BUSY cycle, or the
  // load cycle itself for single-cycle ops.
  always_comb begin
    e_d     = e_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (flush_e) begin
      e_d     = '0;
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end else if (state_q == SEQ_BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = SEQ_IDLE;
        done_d  = 1'b1;
      end
    end else if (!stall_e) begin
      e_d = dec;
      if (dec.alu_op[ALUOP_MULDIV_BIT]) begin
        if (MULTI) begin
          state_d = SEQ_BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign valid_e      = e_q.valid;
  assign RegWriteE    = e_q.reg_write;
  assign MemWriteE    = e_q.mem_write;
  assign PCBranchE    = e_q.pc_branch;
  assign SrcBSelE     = e_q.src_b_sel;
  assign MemtoRegE    = e_q.mem_to_reg;
  assign SrcASelE     = e_q.src_a_sel;
  assign ALUopE       = ALUOP_W'(e_q.alu_op);
  assign immSelE      = e_q.imm_sel;
  assign strCtrlE     = e_q.str_ctrl;
  assign illegal_e    = e_q.illegal;
  assign muldiv_stall = (state_q == SEQ_BUSY);
  assign muldiv_done  = done_q;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: three parameterisations driven in parallel, checked
// every cycle against an op-age reference model plus directed field checks.
module tb_control_pipe;
  import control_pipe_pkg::*;

  localparam int N = 3;
  localparam int MEXT_P [N] = '{1, 0, 1};
  localparam int LAT_P  [N] = '{4, 1, 1};

  logic       clk = 1'b0;
  logic       rst, valid_d, stall_e, flush_e;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [21:0] obs [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic       ve, rw, mw, pcb, sb, m2r, ill, ms, md;
    logic [1:0] sa;
    logic [4:0] alu;
    logic [2:0] imm, str;
    control_pipe #(.M_EXT(MEXT_P[g]), .MULDIV_LAT(LAT_P[g]), .ALUOP_W(5)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .valid_e(ve),
      .RegWriteE(rw), .MemWriteE(mw), .PCBranchE(pcb), .SrcBSelE(sb),
      .MemtoRegE(m2r), .SrcASelE(sa), .ALUopE(alu), .immSelE(imm),
      .strCtrlE(str), .illegal_e(ill), .muldiv_stall(ms), .muldiv_done(md)
    );
    assign obs[g] = {ve, rw, mw, pcb, sb, m2r, sa, alu, imm, str, ill, ms, md};
  end

  // Reference: E contents plus the age (cycles spent in E) of a live MUL/DIV.
  logic [19:0] m_e   [N];
  bit          m_md  [N];
  int          m_age [N];

  function automatic logic [19:0] ref_dec(input logic v, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input int mext);
    logic rw, mw, pcb, sb, m2r;
    logic [1:0] sa;
    logic [4:0] alu;
    logic [2:0] imm;
    bit known, md_op;
    if (!v) return '0;
    {rw, mw, pcb, sb, m2r} = 5'b0;
    sa = 2'b11; alu = 5'd0; imm = 3'd7; known = 1;
    md_op = (op == OP_ALUREG) && (f7 == 7'd1);
    if (op == OP_LOAD)        begin rw = 1; sb = 1; m2r = 1; imm = 3'd0; end
    else if (op == OP_STORE)  begin mw = 1; sb = 1; imm = 3'd1; end
    else if (op == OP_ALUREG) begin rw = 1; alu = {md_op && mext != 0, f7[5], f3}; end
    else if (op == OP_ALUIMM) begin rw = 1; sb = 1; imm = 3'd0; alu = {1'b0, f3 == 3'd5 && f7[5], f3}; end
    else if (op == OP_BRANCH) begin pcb = 1; imm = 3'd2; alu = {2'b00, f3}; end
    else if (op == OP_JAL)    begin rw = 1; pcb = 1; sa = 2'b00; imm = 3'd4; end
    else if (op == OP_JALR)   begin rw = 1; pcb = 1; sa = 2'b00; imm = 3'd0; end
    else if (op == OP_LUI)    begin rw = 1; sb = 1; sa = 2'b01; imm = 3'd3; end
    else if (op == OP_AUIPC)  begin rw = 1; sb = 1; sa = 2'b00; imm = 3'd3; end
    else known = 0;
    if (!known || (md_op && mext == 0)) return {1'b1, 5'b0, 2'b00, 5'd0, 3'd7, f3, 1'b1};
    return {1'b1, rw, mw, pcb, sb, m2r, sa, alu, imm, f3, 1'b0};
  endfunction

  function automatic logic [21:0] ref_obs(input int i);
    logic st, dn;
    st = m_md[i] && (m_age[i] < LAT_P[i]);
    dn = m_md[i] && (m_age[i] == LAT_P[i]);
    return {m_e[i], st, dn};
  endfunction

  task automatic model_edge(input int i, input logic r, input logic v, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic st, input logic fl);
    bit busy;
    busy = m_md[i] && (m_age[i] < LAT_P[i]);
    if (r || fl) begin
      m_e[i] = '0; m_md[i] = 0; m_age[i] = 0;
    end else if (st || busy) begin
      if (m_md[i]) m_age[i]++;
    end else begin
      m_e[i]   = ref_dec(v, op, f3, f7, MEXT_P[i]);
      m_md[i]  = v && (op == OP_ALUREG) && (f7 == 7'd1) && (MEXT_P[i] != 0);
      m_age[i] = m_md[i] ? 1 : 0;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic st, input logic fl);
    logic [21:0] exp;
    rst = r; valid_d = v; opcode = op; funct3 = f3; funct7 = f7; stall_e = st; flush_e = fl;
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i, r, v, op, f3, f7, st, fl);
    #1;
    for (int i = 0; i < N; i++) begin
      exp = ref_obs(i);
      total++;
      assert (obs[i] === exp) else begin
        bad++;
        $error("FAIL %s[%0d] got=%h want=%h", tag, i, obs[i], exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OP_LOAD;   1: return OP_STORE;  2: return OP_ALUREG;
      3: return OP_ALUIMM; 4: return OP_BRANCH; 5: return OP_JAL;
      6: return OP_JALR;   7: return OP_LUI;    8: return OP_AUIPC;
      9: return OP_ALUREG; 10: return OP_ALUREG; 11: return 7'h7f;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [19:0] held;
    logic [6:0]  rop, rf7;
    for (int i = 0; i < N; i++) begin m_e[i] = '0; m_md[i] = 0; m_age[i] = 0; end

    step("reset", 1, 0, 7'd0, 3'd0, 7'd0, 0, 0);
    step("reset", 1, 1, OP_ALUREG, 3'd0, 7'h01, 0, 0);
    chk("reset_outputs", 32'(obs[0]), 32'd0);

    step("sub", 0, 1, OP_ALUREG, 3'd0, 7'h20, 0, 0);
    chk("sub_aluop", 32'(obs[0][13:9]), 32'b01000);
    chk("sub_regwrite", 32'(obs[0][20]), 32'd1);
    chk("sub_srcb", 32'(obs[0][17]), 32'd0);
    chk("sub_srca", 32'(obs[0][15:14]), 32'b11);
    chk("sub_immsel", 32'(obs[0][8:6]), 32'd7);

    step("srai", 0, 1, OP_ALUIMM, 3'd5, 7'h20, 0, 0);
    chk("srai_aluop", 32'(obs[0][13:9]), 32'b01101);
    step("addi", 0, 1, OP_ALUIMM, 3'd0, 7'h7f, 0, 0);
    chk("addi_aluop", 32'(obs[0][13:9]), 32'b00000);

    step("mul", 0, 1, OP_ALUREG, 3'd0, 7'h01, 0, 0);
    held = obs[0][21:2];
    chk("mul_aluop", 32'(obs[0][13:9]), 32'b10000);
    chk("mul_stall_c1", 32'(obs[0][1]), 32'd1);
    chk("mul_noext_illegal", 32'(obs[1][2]), 32'd1);
    chk("mul_noext_regwrite", 32'(obs[1][20]), 32'd0);
    chk("mul_noext_stall", 32'(obs[1][1]), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step("mul_hold", 0, 1, OP_ALUREG, 3'd0, 7'h00, 0, 0);
      chk("mul_e_stable", 32'(obs[0][21:2]), 32'(held));
      chk("mul_stall", 32'(obs[0][1]), 32'(k < 4));
      chk("mul_done", 32'(obs[0][0]), 32'(k == 4));
    end
    step("after_mul", 0, 1, OP_ALUREG, 3'd0, 7'h00, 0, 0);
    chk("after_mul_aluop", 32'(obs[0][13:9]), 32'd0);

    step("div", 0, 1, OP_ALUREG, 3'd4, 7'h01, 0, 0);
    step("div_b2", 0, 0, 7'd0, 3'd0, 7'd0, 0, 0);
    step("div_flush", 0, 0, 7'd0, 3'd0, 7'd0, 0, 1);
    chk("div_flush_valid", 32'(obs[0][21]), 32'd0);
    chk("div_flush_stall", 32'(obs[0][1]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step("div_post", 0, 0, 7'd0, 3'd0, 7'd0, 0, 0);
      chk("div_no_done", 32'(obs[0][0]), 32'd0);
    end

    step("unknown", 0, 1, 7'h7f, 3'd2, 7'd0, 0, 0);
    chk("unknown_illegal", 32'(obs[0][2]), 32'd1);
    chk("unknown_regwrite", 32'(obs[0][20]), 32'd0);
    chk("unknown_stall", 32'(obs[0][1]), 32'd0);

    step("mul_rst", 0, 1, OP_ALUREG, 3'd1, 7'h01, 0, 0);
    step("rst_busy", 1, 0, 7'd0, 3'd0, 7'd0, 0, 0);
    chk("rst_busy_outputs", 32'(obs[0]), 32'd0);
    step("lui", 0, 1, OP_LUI, 3'd3, 7'h15, 0, 0);
    chk("lui_srca", 32'(obs[0][15:14]), 32'b01);
    chk("lui_immsel", 32'(obs[0][8:6]), 32'd3);
    chk("lui_regwrite", 32'(obs[0][20]), 32'd1);

    step("flush_mul_d", 0, 1, OP_ALUREG, 3'd0, 7'h01, 0, 1);
    chk("flush_mul_valid", 32'(obs[0][21]), 32'd0);
    chk("flush_mul_stall", 32'(obs[0][1]), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rop = pick_op($urandom_range(0, 13));
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, rop,
           3'($urandom), rf7, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
